// File: rtl/exu_lsu_split_pkg.sv
// exu_lsu_split_pkg
//   Shared definitions for the EXU address-generation / load-store unit:
//   access-size encodings, FSM state encodings, opcode field widths and a
//   small helper that turns a size code into a byte count.
package exu_lsu_split_pkg;

  localparam int CIRNO_LSU_SIZE_W = 2;

  typedef enum logic [CIRNO_LSU_SIZE_W-1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_DONE
  } state_e;

  function automatic int size_bytes(size_e s);
    return 1 << int'(s);
  endfunction

endpackage

// File: rtl/exu_lsu_lane.sv
// exu_lsu_lane
//   Combinational byte-lane shifter shared by both bus beats.
//   Ports:
//     off    - byte offset of the effective address within a bus word
//     size   - access size code
//     uns    - zero-extend (1) or sign-extend (0) the load result
//     beat   - 0: first beat (shift up by off), 1: second beat (remainder)
//     wdat_i - LSB-aligned store data
//     rdat0  - read data of the first beat
//     rdat1  - read data of the second beat
//     wen    - byte write enables for the selected beat
//     wdat_o - lane-shifted store data for the selected beat
//     res    - merged, truncated and extended load result
module exu_lsu_lane
  import exu_lsu_split_pkg::*;
#(
  parameter  int DW = 32,
  localparam int NB = DW / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0] off,
  input  size_e         size,
  input  logic          uns,
  input  logic          beat,
  input  logic [DW-1:0] wdat_i,
  input  logic [DW-1:0] rdat0,
  input  logic [DW-1:0] rdat1,
  output logic [NB-1:0] wen,
  output logic [DW-1:0] wdat_o,
  output logic [DW-1:0] res
);

  logic [OW:0]     rem;
  logic [2*NB-1:0] mask;
  logic [2*NB-1:0] mask_sh;
  logic [DW-1:0]   merged;

  // rem is the number of bytes of the first beat that lie above off; the
  // second beat picks up whatever did not fit. The mask is kept twice as
  // wide as a word so the upper half can be shifted down for beat 1.
  always_comb begin
    rem = (OW+1)'(NB) - {1'b0, off};
    unique case (size)
      SZ_BYTE: mask = (2*NB)'(8'h01);
      SZ_HALF: mask = (2*NB)'(8'h03);
      SZ_WORD: mask = (2*NB)'(8'h0F);
      SZ_DWORD: mask = (2*NB)'(8'hFF);
    endcase
    if (beat) begin
      mask_sh = mask >> rem;
      wdat_o  = wdat_i >> {rem, 3'b000};
    end else begin
      mask_sh = mask << off;
      wdat_o  = wdat_i << {off, 3'b000};
    end
    wen = mask_sh[NB-1:0];

    // With off=0 the rem shift equals DW and rdat1 contributes nothing.
    merged = (rdat0 >> {off, 3'b000}) | (rdat1 << {rem, 3'b000});
    unique case (size)
      SZ_BYTE: res = uns ? DW'(merged[7:0])  : DW'($signed(merged[7:0]));
      SZ_HALF: res = uns ? DW'(merged[15:0]) : DW'($signed(merged[15:0]));
      SZ_WORD: res = uns ? DW'(merged[31:0]) : DW'($signed(merged[31:0]));
      SZ_DWORD: res = merged;
    endcase
  end

endmodule

// File: rtl/exu_lsu_split.sv
// exu_lsu_split
//   Address-generation / load-store unit. Adds opn1+imm, issues one or two
//   word-wide bus beats with a valid/ready handshake, merges split loads
//   and returns the extended result. Misaligned word-crossing accesses are
//   either split (SPLIT_MISAL=1) or trapped via o_misal (SPLIT_MISAL=0).
//   Ports:
//     clk, rst                    - clock, synchronous active-high reset
//     hs_ex4ag_val / hs_ag4ex_rdy - EXU issue handshake
//     i_ld, i_st, i_size, i_unsigned, i_opn1, i_im, i_opn2 - op fields
//     hs_ag4ls_val / hs_ls4ag_rdy - bus request handshake
//     o_ls_adr, o_ls_ren, o_ls_wen, o_ls_wdat - bus request fields
//     i_ls_rvld, i_ls_rdat        - bus read return
//     o_done, o_res, o_misal      - completion pulse, load result, trap
module exu_lsu_split
  import exu_lsu_split_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SPLIT_MISAL = 1,
  localparam int NB = DW / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hs_ex4ag_val,
  output logic                        hs_ag4ex_rdy,
  input  logic                        i_ld,
  input  logic                        i_st,
  input  logic [CIRNO_LSU_SIZE_W-1:0] i_size,
  input  logic                        i_unsigned,
  input  logic [AW-1:0]               i_opn1,
  input  logic [AW-1:0]               i_im,
  input  logic [DW-1:0]               i_opn2,
  output logic                        hs_ag4ls_val,
  input  logic                        hs_ls4ag_rdy,
  output logic [AW-1:0]               o_ls_adr,
  output logic                        o_ls_ren,
  output logic [NB-1:0]               o_ls_wen,
  output logic [DW-1:0]               o_ls_wdat,
  input  logic                        i_ls_rvld,
  input  logic [DW-1:0]               i_ls_rdat,
  output logic                        o_done,
  output logic [DW-1:0]               o_res,
  output logic                        o_misal
);

  state_e        state;
  logic [AW-1:0] ea_q;
  size_e         size_q;
  logic          uns_q;
  logic          ld_q;
  logic          cross_q;
  logic [DW-1:0] opn2_q;
  logic [DW-1:0] rdat0_q;

  logic          accept;
  logic [AW-1:0] ea_in;
  size_e         size_in;
  logic [OW-1:0] off_in;
  logic          cross_in;
  logic [AW-1:0] adr1;

  logic [OW-1:0] ln_off;
  size_e         ln_size;
  logic          ln_uns;
  logic          ln_beat;
  logic [DW-1:0] ln_wdat_i;
  logic [DW-1:0] ln_rdat0;
  logic [NB-1:0] ln_wen;
  logic [DW-1:0] ln_wdat_o;
  logic [DW-1:0] ln_res;

  assign hs_ag4ex_rdy = (state == ST_IDLE);
  assign accept       = hs_ex4ag_val & hs_ag4ex_rdy & (i_ld | i_st);
  assign ea_in        = i_opn1 + i_im;
  assign off_in       = ea_in[OW-1:0];
  assign adr1         = {ea_q[AW-1:OW], {OW{1'b0}}} + AW'(NB);

  // A dword request on a 32-bit bus is illegal and degrades to a word.
  always_comb begin
    size_in = size_e'(i_size);
    if (DW == 32 && size_in == SZ_DWORD) size_in = SZ_WORD;
    cross_in = (int'(off_in) + size_bytes(size_in)) > NB;
  end

  // The single lane shifter sees the incoming op while idle (to build the
  // first beat) and the registered op afterwards (second beat and result).
  // The final read beat merges straight from the bus so o_res can register
  // in the same edge that enters DONE.
  always_comb begin
    if (state == ST_IDLE) begin
      ln_off    = off_in;
      ln_size   = size_in;
      ln_uns    = i_unsigned;
      ln_wdat_i = i_opn2;
      ln_beat   = 1'b0;
    end else begin
      ln_off    = ea_q[OW-1:0];
      ln_size   = size_q;
      ln_uns    = uns_q;
      ln_wdat_i = opn2_q;
      ln_beat   = 1'b1;
    end
    ln_rdat0 = (state == ST_WAIT0) ? i_ls_rdat : rdat0_q;
  end

  exu_lsu_lane #(.DW(DW)) u_lane (
    .off    (ln_off),
    .size   (ln_size),
    .uns    (ln_uns),
    .beat   (ln_beat),
    .wdat_i (ln_wdat_i),
    .rdat0  (ln_rdat0),
    .rdat1  (i_ls_rdat),
    .wen    (ln_wen),
    .wdat_o (ln_wdat_o),
    .res    (ln_res)
  );

  // Main FSM. Bus request fields are loaded on entry to REQ0/REQ1 and held
  // until the bus accepts; completion and trap pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ea_q         <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      ld_q         <= 1'b0;
      cross_q      <= 1'b0;
      opn2_q       <= '0;
      rdat0_q      <= '0;
      hs_ag4ls_val <= 1'b0;
      o_ls_adr     <= '0;
      o_ls_ren     <= 1'b0;
      o_ls_wen     <= '0;
      o_ls_wdat    <= '0;
      o_done       <= 1'b0;
      o_res        <= '0;
      o_misal      <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_misal <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            ea_q    <= ea_in;
            size_q  <= size_in;
            uns_q   <= i_unsigned;
            ld_q    <= i_ld;
            cross_q <= cross_in;
            opn2_q  <= i_opn2;
            if (cross_in && SPLIT_MISAL == 0) begin
              state   <= ST_DONE;
              o_done  <= 1'b1;
              o_misal <= 1'b1;
            end else begin
              state        <= ST_REQ0;
              hs_ag4ls_val <= 1'b1;
              o_ls_adr     <= {ea_in[AW-1:OW], {OW{1'b0}}};
              o_ls_ren     <= i_ld;
              o_ls_wen     <= i_ld ? '0 : ln_wen;
              o_ls_wdat    <= i_ld ? '0 : ln_wdat_o;
            end
          end
        end
        ST_REQ0: begin
          if (hs_ls4ag_rdy) begin
            hs_ag4ls_val <= 1'b0;
            o_ls_ren     <= 1'b0;
            o_ls_wen     <= '0;
            if (ld_q) begin
              state <= ST_WAIT0;
            end else if (cross_q) begin
              state        <= ST_REQ1;
              hs_ag4ls_val <= 1'b1;
              o_ls_adr     <= adr1;
              o_ls_wen     <= ln_wen;
              o_ls_wdat    <= ln_wdat_o;
            end else begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end
          end
        end
        ST_WAIT0: begin
          if (i_ls_rvld) begin
            rdat0_q <= i_ls_rdat;
            if (cross_q) begin
              state        <= ST_REQ1;
              hs_ag4ls_val <= 1'b1;
              o_ls_adr     <= adr1;
              o_ls_ren     <= 1'b1;
            end else begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_res  <= ln_res;
            end
          end
        end
        ST_REQ1: begin
          if (hs_ls4ag_rdy) begin
            hs_ag4ls_val <= 1'b0;
            o_ls_ren     <= 1'b0;
            o_ls_wen     <= '0;
            if (ld_q) begin
              state <= ST_WAIT1;
            end else begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end
          end
        end
        ST_WAIT1: begin
          if (i_ls_rvld) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_res  <= ln_res;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
